// File: rtl/key_led_pkg.sv
// key_led_pkg
// Shared definitions for the single-key LED mode controller:
//   - display mode encodings (mode_e)
//   - LED bank width
//   - the pattern each mode starts from when it is entered
//   - helpers for stepping the mode and looking up its load pattern
package key_led_pkg;

    localparam int LED_W = 4;

    typedef enum logic [1:0] {
        MODE_SHL   = 2'd0,
        MODE_SHR   = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_ON    = 2'd3
    } mode_e;

    localparam logic [LED_W-1:0] LOAD_SHL   = 4'b0001;
    localparam logic [LED_W-1:0] LOAD_SHR   = 4'b1000;
    localparam logic [LED_W-1:0] LOAD_BLINK = 4'b0000;
    localparam logic [LED_W-1:0] LOAD_ON    = 4'b1111;

    // Modes advance in encoding order and wrap from MODE_ON back to MODE_SHL.
    function automatic mode_e next_mode(input mode_e m);
        logic [1:0] v;
        v = m + 2'd1;
        return mode_e'(v);
    endfunction

    function automatic logic [LED_W-1:0] load_pattern(input mode_e m);
        logic [LED_W-1:0] p;
        case (m)
            MODE_SHL:   p = LOAD_SHL;
            MODE_SHR:   p = LOAD_SHR;
            MODE_BLINK: p = LOAD_BLINK;
            default:    p = LOAD_ON;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/key_led_debounce.sv
// key_debounce
// Synchronizes a raw active-low push-button, debounces it and emits a
// one-cycle press pulse on each accepted released->pressed transition.
// Ports:
//   clk     system clock, rising edge
//   rst_n   synchronous active-low reset
//   key_in  raw asynchronous key (idle 1, pressed 0)
//   press   registered 1-cycle pulse when the debounced key goes 1->0
// Parameter DEBOUNCE_CYCLES (>= 2): cycles the synchronized key must
// disagree with the stable state before the new level is accepted.
module key_debounce
    import key_led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchronizer; resets to the released level so a key held
    // through reset is seen as a fresh press afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    // The counter only runs while the synchronized key disagrees with the
    // stable level, so any bounce back clears it. The press pulse is raised
    // on the same edge the stable level falls, and only for falls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync2;
                cnt    <= '0;
                press  <= ~sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/key_led_ctrl.sv
// key_led_ctrl
// Single-key LED mode controller. Each debounced press advances a 2-bit
// display mode; the LED bank shows the pattern for that mode, stepping once
// every STEP_CYCLES cycles.
// Ports:
//   clk    system clock (50 MHz), rising edge
//   rst_n  synchronous active-low reset
//   key    raw push-button, active-low
//   mode   current display mode (debug visibility)
//   led    LED drive, led[0] is the rightmost LED
// Parameters: DEBOUNCE_CYCLES (>= 2), STEP_CYCLES (>= 2).
// Build option: define LED_ACTIVE_LOW_EN to drive led inverted for boards
// with active-low LEDs; mode and timing are unchanged.
module key_led_ctrl
    import key_led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int STEP_CYCLES     = 25000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key,
    output logic [1:0]       mode,
    output logic [LED_W-1:0] led
);

    localparam int STEP_W = $clog2(STEP_CYCLES);
    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(STEP_CYCLES - 1);

    logic              press;
    logic              tick;
    mode_e             mode_q;
    mode_e             mode_d;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_d;
    logic [LED_W-1:0]  pattern_q;
    logic [LED_W-1:0]  pattern_d;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_in (key),
        .press  (press)
    );

    assign tick = (step_q == STEP_MAX);

    // Next-state logic. A press takes priority over a coincident tick: the
    // new mode's load pattern is taken and the step timer restarts, so the
    // first step of the new mode comes a full STEP_CYCLES later.
    always_comb begin
        mode_d    = mode_q;
        pattern_d = pattern_q;
        step_d    = step_q + STEP_W'(1);
        if (press) begin
            mode_d    = next_mode(mode_q);
            pattern_d = load_pattern(mode_d);
            step_d    = '0;
        end else if (tick) begin
            step_d = '0;
            case (mode_q)
                MODE_SHL:   pattern_d = {pattern_q[LED_W-2:0], pattern_q[LED_W-1]};
                MODE_SHR:   pattern_d = {pattern_q[0], pattern_q[LED_W-1:1]};
                MODE_BLINK: pattern_d = ~pattern_q;
                default:    pattern_d = pattern_q;
            endcase
        end
    end

    // State register for mode, step timer and LED pattern.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q    <= MODE_SHL;
            step_q    <= '0;
            pattern_q <= LOAD_SHL;
        end else begin
            mode_q    <= mode_d;
            step_q    <= step_d;
            pattern_q <= pattern_d;
        end
    end

    assign mode = mode_q;

`ifdef LED_ACTIVE_LOW_EN
    assign led = ~pattern_q;
`else
    assign led = pattern_q;
`endif

endmodule

// File: tb/tb_key_led_ctrl.sv
// tb_key_led_ctrl
// Self-checking bench for key_led_ctrl with DEBOUNCE_CYCLES=8 and
// STEP_CYCLES=16. A behavioural model derives mode from the key history
// (key seen two cycles late must disagree with the accepted level for 8
// cycles in a row) and derives led from mode plus time since the last
// mode load. Honours LED_ACTIVE_LOW_EN the same way the design does.
module tb_key_led_ctrl;

    localparam int DB = 8;
    localparam int ST = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       key   = 1'b1;
    logic [1:0] mode;
    logic [3:0] led;

    int checks = 0;
    int errors = 0;
    bit compare_on = 1'b0;

    // Model state
    bit hist[$];
    bit m_stable  = 1'b1;
    bit pend      = 1'b0;
    int last_flip = 0;
    int m_mode    = 0;
    int elapsed   = 0;

    key_led_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .STEP_CYCLES    (ST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key),
        .mode  (mode),
        .led   (led)
    );

    always #10 clk = ~clk;

    function automatic logic [3:0] phys(input logic [3:0] p);
`ifdef LED_ACTIVE_LOW_EN
        return ~p;
`else
        return p;
`endif
    endfunction

    // Pattern from mode and number of completed steps since the last load.
    function automatic logic [3:0] exp_led();
        int t;
        logic [3:0] p;
        t = elapsed / ST;
        case (m_mode)
            0:       p = 4'b0001 << (t % 4);
            1:       p = 4'b1000 >> (t % 4);
            2:       p = ((t % 2) == 1) ? 4'b1111 : 4'b0000;
            default: p = 4'b1111;
        endcase
        return phys(p);
    endfunction

    // Model: advances on every rising edge using the key level held there.
    initial begin
        int  n;
        bit  all_diff;
        bit  s;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                hist.delete();
                m_stable  = 1'b1;
                pend      = 1'b0;
                last_flip = 0;
                m_mode    = 0;
                elapsed   = 0;
            end else begin
                if (pend) begin
                    m_mode  = (m_mode + 1) % 4;
                    elapsed = 0;
                    pend    = 1'b0;
                end else begin
                    elapsed++;
                end
                hist.push_back(key);
                n = hist.size();
                if (n - DB + 1 >= last_flip + 1) begin
                    all_diff = 1'b1;
                    for (int j = n - DB + 1; j <= n; j++) begin
                        s = (j - 2 >= 1) ? hist[j - 3] : 1'b1;
                        if (s == m_stable) all_diff = 1'b0;
                    end
                    if (all_diff) begin
                        m_stable  = ~m_stable;
                        last_flip = n;
                        if (!m_stable) pend = 1'b1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of DUT against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (compare_on) begin
                checks++;
                if (mode !== 2'(m_mode) || led !== exp_led()) begin
                    errors++;
                    $display("[TB] FAIL cycle_compare t=%0t mode=%0d want %0d led=%b want %b",
                             $time, mode, m_mode, led, exp_led());
                end
            end
        end
    end

    task automatic applyStimulus(input logic k, input int n);
        key = k;
        repeat (n) @(negedge clk);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        key   = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        compare_on = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic [1:0] em, input logic [3:0] ep);
        checks++;
        if (mode !== em || led !== phys(ep)) begin
            errors++;
            $display("[TB] FAIL %s mode=%0d want %0d led=%b want %b", name, mode, em, led, phys(ep));
        end
    endtask

    task automatic checkModel(input string name, input int em, input logic [3:0] ep);
        checks++;
        if (m_mode != em || exp_led() !== phys(ep)) begin
            errors++;
            $display("[TB] FAIL %s model mode=%0d want %0d led=%b want %b", name, m_mode, em, exp_led(), phys(ep));
        end
    endtask

    task automatic checkLatency(input string name, input int lat, input int want);
        checks++;
        if (lat != want) begin
            errors++;
            $display("[TB] FAIL %s latency=%0d want %0d", name, lat, want);
        end
    endtask

    // Drive key low and count cycles until mode moves (-1 on timeout).
    task automatic pressMeasure(output int lat);
        logic [1:0] prev;
        prev = mode;
        key  = 1'b0;
        lat  = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (mode !== prev) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        @(negedge clk);

        // Reset and free-running rotate-left
        doReset();
        checkOutput("reset", 2'd0, 4'b0001);
        checkModel("model_reset", 0, 4'b0001);
        applyStimulus(1'b1, 16);
        checkOutput("rot16", 2'd0, 4'b0010);
        checkModel("model_rot16", 0, 4'b0010);
        applyStimulus(1'b1, 48);
        checkOutput("rot64", 2'd0, 4'b0001);

        // Clean press
        doReset();
        pressMeasure(lat);
        checkLatency("clean_lat", lat, DB + 3);
        checkOutput("clean_load", 2'd1, 4'b1000);
        checkModel("model_clean_load", 1, 4'b1000);
        applyStimulus(1'b0, 9);
        applyStimulus(1'b1, 7);
        checkOutput("clean_step", 2'd1, 4'b0100);
        applyStimulus(1'b1, 20);

        // Bouncy press: 3-cycle toggles never survive debounce
        doReset();
        for (int i = 0; i < 10; i++) applyStimulus((i % 2) == 1, 3);
        pressMeasure(lat);
        checkLatency("bounce_lat", lat, DB + 3);
        checkOutput("bounce_mode", 2'd1, 4'b1000);
        applyStimulus(1'b0, 20);
        applyStimulus(1'b1, 30);
        checkOutput("bounce_once", 2'd1, 4'b0001);

        // Four press/release pairs walk through every mode
        doReset();
        pressMeasure(lat);
        checkOutput("seq_m1", 2'd1, 4'b1000);
        applyStimulus(1'b0, 9);
        applyStimulus(1'b1, 20);
        pressMeasure(lat);
        checkLatency("seq_m2_lat", lat, DB + 3);
        checkOutput("seq_m2_load", 2'd2, 4'b0000);
        checkModel("model_blink_load", 2, 4'b0000);
        applyStimulus(1'b0, 9);
        applyStimulus(1'b1, 7);
        checkOutput("seq_m2_blink", 2'd2, 4'b1111);
        applyStimulus(1'b1, 13);
        pressMeasure(lat);
        checkOutput("seq_m3_load", 2'd3, 4'b1111);
        applyStimulus(1'b0, 16);
        checkOutput("seq_m3_16", 2'd3, 4'b1111);
        applyStimulus(1'b1, 16);
        checkOutput("seq_m3_32", 2'd3, 4'b1111);
        applyStimulus(1'b1, 16);
        checkOutput("seq_m3_48", 2'd3, 4'b1111);
        checkModel("model_on_48", 3, 4'b1111);
        pressMeasure(lat);
        checkOutput("seq_m0_wrap", 2'd0, 4'b0001);
        applyStimulus(1'b0, 9);
        applyStimulus(1'b1, 20);

        // Long hold gives a single event
        doReset();
        applyStimulus(1'b0, 200);
        checkOutput("hold_once", 2'd1, 4'b0001);
        applyStimulus(1'b1, 20);

        // Reset in the middle of a debounce discards the press
        doReset();
        applyStimulus(1'b0, 5);
        rst_n = 1'b0;
        key   = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("mid_reset", 2'd0, 4'b0001);
        applyStimulus(1'b1, 30);
        checkOutput("mid_reset_after", 2'd0, 4'b0010);

        compare_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

endmodule
